// File: rtl/csd_twiddle_sched.sv
// csd_twiddle_sched: frames samples into an external CSD multiplier and registers the product one-deep.
// Define CSD_SCHED_ERR_EN to add the sticky framing-error output err_sop.
`default_nettype none

module csd_twiddle_sched #(
  parameter int NBITS      = 12,
  parameter int NBITScoeff = 11,
  parameter int NBITS_out  = NBITS + NBITScoeff + 1,
  parameter int FRAME_LEN  = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*NBITS-1:0]     in_muestra,
  input  logic                   in_valid,
  input  logic                   in_sop,
  output logic                   in_ready,
  output logic [1:0]             csd_num_ciclo,
  output logic [2*NBITS-1:0]     mult_muestra,
  input  logic [2*NBITS_out-1:0] mult_result,
  output logic [2*NBITS_out-1:0] out_result,
  output logic                   out_valid,
  output logic                   out_sop,
  output logic                   out_eop,
`ifdef CSD_SCHED_ERR_EN
  output logic                   err_sop,
`endif
  input  logic                   out_ready
);

  localparam int               IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_take;
  logic             accept;
  logic             emit;
  logic             take;
  logic             last;

  assign in_ready     = !out_valid || out_ready;
  assign accept       = in_valid && in_ready;
  assign emit         = out_valid && out_ready;
  assign mult_muestra = in_muestra;

  // Index this transfer would occupy; in_sop always restarts, even on the last slot.
  assign idx_take      = in_sop ? '0 : idx + 1'b1;
  assign last          = (idx_take == LAST_IDX);
  assign csd_num_ciclo = idx_take[1:0];

  // Transfers accepted in IDLE without in_sop are swallowed.
  assign take = accept && (in_sop || (state == RUN));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && in_sop) state_nxt = RUN;
      RUN:     if (accept && last)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx        <= '0;
      out_result <= '0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_valid  <= 1'b0;
    end else if (take) begin
      idx        <= idx_take;
      out_result <= mult_result;
      out_sop    <= in_sop;
      out_eop    <= last;
      out_valid  <= 1'b1;
    end else if (emit) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef CSD_SCHED_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_sop <= 1'b0;
    end else if (accept && (in_sop ? (state == RUN) : (state == IDLE))) begin
      err_sop <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_csd_twiddle_sched.sv
// tb_csd_twiddle_sched: randomized and directed checks of csd_twiddle_sched against a queue-based frame model.
`default_nettype none

module tb_csd_twiddle_sched;

  localparam int NBITS = 12;
  localparam int NBC   = 11;
  localparam int NBO   = NBITS + NBC + 1;
  localparam int FL    = 128;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [2*NBITS-1:0]   in_muestra = '0;
  logic                 in_valid = 1'b0;
  logic                 in_sop = 1'b0;
  logic                 in_ready;
  logic [1:0]           csd_num_ciclo;
  logic [2*NBITS-1:0]   mult_muestra;
  logic [2*NBO-1:0]     mult_result;
  logic [2*NBO-1:0]     out_result;
  logic                 out_valid;
  logic                 out_sop;
  logic                 out_eop;
  logic                 out_ready = 1'b0;
`ifdef CSD_SCHED_ERR_EN
  logic                 err_sop;
`endif

  always #5 clk = ~clk;

  function automatic logic [2*NBO-1:0] sx(input logic [2*NBITS-1:0] s);
    logic signed [NBITS-1:0] re;
    logic signed [NBITS-1:0] im;
    logic signed [NBO-1:0]   re_x;
    logic signed [NBO-1:0]   im_x;
    re   = s[2*NBITS-1:NBITS];
    im   = s[NBITS-1:0];
    re_x = NBO'(re);
    im_x = NBO'(im);
    return {re_x, im_x};
  endfunction

  assign mult_result = sx(mult_muestra);

  csd_twiddle_sched #(
    .NBITS(NBITS), .NBITScoeff(NBC), .NBITS_out(NBO), .FRAME_LEN(FL)
  ) dut (
    .clk(clk), .rst(rst), .in_muestra(in_muestra), .in_valid(in_valid), .in_sop(in_sop),
    .in_ready(in_ready), .csd_num_ciclo(csd_num_ciclo), .mult_muestra(mult_muestra),
    .mult_result(mult_result), .out_result(out_result), .out_valid(out_valid),
    .out_sop(out_sop), .out_eop(out_eop),
`ifdef CSD_SCHED_ERR_EN
    .err_sop(err_sop),
`endif
    .out_ready(out_ready)
  );

  typedef struct packed {
    logic [2*NBO-1:0] res;
    logic             sop;
    logic             eop;
  } item_t;

  item_t q[$];
  bit    m_in_frame = 1'b0;
  int    m_pos = 0;
  bit    m_err = 1'b0;
  int    n_chk = 0;
  int    n_fail = 0;
  int    n_emit = 0;
  int    n_sop_o = 0;
  int    n_eop_o = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the model to the next rising edge.
  task automatic step();
    bit    acc;
    bit    emit;
    item_t it;
    @(negedge clk);
    if (!rst) begin
      q.delete();
      m_in_frame = 1'b0;
      m_pos      = 0;
      m_err      = 1'b0;
      chk("rst_out_result", out_result, 0);
      chk("rst_out_sop", out_sop, 0);
      chk("rst_out_eop", out_eop, 0);
    end
    chk("in_ready", in_ready, (q.size() == 0) || out_ready);
    chk("out_valid", out_valid, q.size() != 0);
    chk("mult_muestra", mult_muestra, in_muestra);
    if (q.size() != 0) begin
      chk("out_result", out_result, q[0].res);
      chk("out_sop", out_sop, q[0].sop);
      chk("out_eop", out_eop, q[0].eop);
    end
`ifdef CSD_SCHED_ERR_EN
    chk("err_sop", err_sop, m_err);
`endif
    if (rst) begin
      acc  = in_valid && ((q.size() == 0) || out_ready);
      emit = (q.size() != 0) && out_ready;
      if (emit) begin
        n_emit++;
        if (q[0].sop) n_sop_o++;
        if (q[0].eop) n_eop_o++;
        void'(q.pop_front());
      end
      if (acc) begin
        if (in_sop) begin
          if (m_in_frame) m_err = 1'b1;
          m_in_frame = 1'b1;
          m_pos      = 0;
          chk("csd", csd_num_ciclo, 0);
          it = '{res: sx(in_muestra), sop: 1'b1, eop: 1'b0};
          q.push_back(it);
        end else if (m_in_frame) begin
          m_pos = (m_pos + 1) % FL;
          chk("csd", csd_num_ciclo, m_pos % 4);
          it = '{res: sx(in_muestra), sop: 1'b0, eop: (m_pos == FL - 1)};
          q.push_back(it);
          if (m_pos == FL - 1) m_in_frame = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    in_sop = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    int e0, s0, p0, k, cyc;
    bit acc;

    // Reset state
    do_reset();

    // Back-to-back frame, downstream always ready
    out_ready = 1'b1;
    e0 = n_emit; s0 = n_sop_o; p0 = n_eop_o;
    for (int i = 0; i < FL; i++) begin
      in_valid   = 1'b1;
      in_sop     = (i == 0);
      in_muestra = 24'($urandom);
      #1;
      chk("b2b_csd_seq", csd_num_ciclo, i % 4);
      step();
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    step();
    step();
    chk("b2b_emits", n_emit - e0, FL);
    chk("b2b_sops", n_sop_o - s0, 1);
    chk("b2b_eops", n_eop_o - p0, 1);

    // Backpressure hold: real=100, imag=-50
    in_valid   = 1'b1;
    in_sop     = 1'b1;
    in_muestra = {12'd100, 12'hFCE};
    step();
    in_sop     = 1'b0;
    in_muestra = 24'($urandom);
    out_ready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_result", out_result, 48'h000064FFFFCE);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    e0 = n_emit;
    #1;
    chk("hold_release_valid", out_valid, 1);
    chk("hold_release_result", out_result, 48'h000064FFFFCE);
    step();
    chk("hold_emitted", n_emit - e0, 1);
    chk("hold_drained", out_valid, 0);

    // in_sop restart at sample 5
    do_reset();
    for (int i = 0; i < 9; i++) begin
      in_valid   = 1'b1;
      in_sop     = (i == 0) || (i == 5);
      in_muestra = 24'($urandom);
      #1;
      chk("restart_csd", csd_num_ciclo, (i < 5) ? (i % 4) : (i - 5));
`ifdef CSD_SCHED_ERR_EN
      chk("restart_err", err_sop, i > 5);
`endif
      step();
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    step();

    // Samples without in_sop after reset are discarded
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_valid   = 1'b1;
      in_sop     = 1'b0;
      out_ready  = 1'($urandom_range(0, 1));
      in_muestra = 24'($urandom);
      #1;
      chk("nosop_in_ready", in_ready, 1);
      chk("nosop_out_valid", out_valid, 0);
      step();
    end
`ifdef CSD_SCHED_ERR_EN
    chk("nosop_err", err_sop, 1);
`endif

    // Reset asserted at sample 60 mid-frame
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i <= 60; i++) begin
      in_valid   = 1'b1;
      in_sop     = (i == 0);
      in_muestra = 24'($urandom);
      step();
    end
    chk("midrst_valid_before", out_valid, 1);
    rst = 1'b0;
    #1;
    chk("midrst_async_valid", out_valid, 0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid   = 1'b1;
      in_sop     = 1'b0;
      in_muestra = 24'($urandom);
      #1;
      chk("midrst_nosop_valid", out_valid, 0);
      step();
    end
    in_sop = 1'b1;
    #1;
    chk("midrst_new_sop_csd", csd_num_ciclo, 0);
    step();
    in_valid = 1'b0;
    in_sop   = 1'b0;
    step();

    // Three frames with random valid and random out_ready
    do_reset();
    e0 = n_emit; s0 = n_sop_o; p0 = n_eop_o;
    k = 0;
    cyc = 0;
    while (k < 3 * FL && cyc < 5000) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      in_sop     = (k % FL == 0);
      in_muestra = 24'($urandom);
      out_ready  = 1'($urandom_range(0, 1));
      #1;
      acc = in_valid && in_ready;
      step();
      if (acc) k++;
      cyc++;
    end
    chk("rand_accept_budget", k, 3 * FL);
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();
    chk("rand_emits", n_emit - e0, 3 * FL);
    chk("rand_sops", n_sop_o - s0, 3);
    chk("rand_eops", n_eop_o - p0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
